// File: rtl/add_share_arbiter.sv
// Round-robin arbiter with burst lock sharing one W-bit adder across N clients (operand reg, result reg).
// Optional ADD_ARB_SAT_EN adds a per-client sat input that clamps overflowing sums to all ones.
module add_share_arbiter #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int IDW  = 2,
    parameter int MAXB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [N*W-1:0]   op_a,
    input  logic [N*W-1:0]   op_b,
    input  logic [N-1:0]     op_ci,
`ifdef ADD_ARB_SAT_EN
    input  logic [N-1:0]     sat,
`endif
    output logic [N-1:0]     gnt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDW-1:0]   res_id,
    output logic [W-1:0]     res_sum,
    output logic             res_co
);

    typedef enum logic {ARB, BURST} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, rr_nx;
    logic [IDW-1:0] owner, owner_nx;
    logic [3:0]     burst_cnt, cnt_nx;

    logic           s1_valid;
    logic [W-1:0]   s1_a, s1_b;
    logic           s1_ci;
    logic [IDW-1:0] s1_id;
    logic           s1_sat;

    logic           s2_adv, s1_acc;
    logic           found;
    logic [IDW-1:0] gidx, cand;
    logic [W-1:0]   sel_a, sel_b;
    logic           sel_ci, sel_sat;
    logic [W:0]     sum_full;

    assign s2_adv = !res_valid || res_ready;
    assign s1_acc = s2_adv || !s1_valid;

    // Candidate selection: rotating search after rr_ptr in ARB, owner only in BURST.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        if (state == ARB) begin
            for (int unsigned k = 1; k <= N; k++) begin
                cand = IDW'((32'(rr_ptr) + k) % N);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    gidx  = cand;
                end
            end
        end else if (req[owner]) begin
            found = 1'b1;
            gidx  = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            owner     <= owner_nx;
            burst_cnt <= cnt_nx;
        end
    end

    // Nothing moves while S1 cannot accept, so a stall freezes state and counter.
    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        cnt_nx   = burst_cnt;
        if (s1_acc) begin
            case (state)
                ARB: begin
                    if (found) begin
                        rr_nx = gidx;
                        if (lock[gidx] && MAXB > 1) begin
                            state_nx = BURST;
                            owner_nx = gidx;
                            cnt_nx   = 4'd1;
                        end
                    end
                end
                BURST: begin
                    if (found && lock[owner] && (burst_cnt + 4'd1 != 4'(MAXB))) begin
                        cnt_nx = burst_cnt + 4'd1;
                    end else begin
                        state_nx = ARB;
                        cnt_nx   = '0;
                    end
                end
                default: state_nx = ARB;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (s1_acc && found) gnt[gidx] = 1'b1;
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_ci  = 1'b0;
        sel_sat = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gidx == IDW'(i)) begin
                sel_a  = op_a[i*W +: W];
                sel_b  = op_b[i*W +: W];
                sel_ci = op_ci[i];
`ifdef ADD_ARB_SAT_EN
                sel_sat = sat[i];
`endif
            end
        end
    end

    assign sum_full = {1'b0, s1_a} + {1'b0, s1_b} + {{W{1'b0}}, s1_ci};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_ci     <= 1'b0;
            s1_id     <= '0;
            s1_sat    <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            res_co    <= 1'b0;
        end else begin
            if (s1_acc) begin
                s1_valid <= |gnt;
                if (|gnt) begin
                    s1_a   <= sel_a;
                    s1_b   <= sel_b;
                    s1_ci  <= sel_ci;
                    s1_id  <= gidx;
                    s1_sat <= sel_sat;
                end
            end
            if (s2_adv) begin
                res_valid <= s1_valid;
                if (s1_valid) begin
                    res_id <= s1_id;
                    res_co <= sum_full[W];
`ifdef ADD_ARB_SAT_EN
                    res_sum <= (s1_sat && sum_full[W]) ? '1 : sum_full[W-1:0];
`else
                    res_sum <= sum_full[W-1:0];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_add_share_arbiter;
    localparam int W = 8, N = 4, IDW = 2, MAXB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req, lock, op_ci, gnt;
    logic [N*W-1:0]   op_a, op_b;
    logic             res_valid, res_ready, res_co;
    logic [IDW-1:0]   res_id;
    logic [W-1:0]     res_sum;
`ifdef ADD_ARB_SAT_EN
    logic [N-1:0]     sat;
`endif

    always #5 clk = ~clk;

    add_share_arbiter #(.W(W), .N(N), .IDW(IDW), .MAXB(MAXB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .op_a(op_a), .op_b(op_b), .op_ci(op_ci),
`ifdef ADD_ARB_SAT_EN
        .sat(sat),
`endif
        .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sum(res_sum), .res_co(res_co)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight results as queues, arbitration as plain variables.
    int q_id[$], q_sum[$], q_co[$], q_rdy[$];
    int cyc = 0;
    bit m_burst = 1'b0;
    int m_owner = 0, m_cnt = 0, m_ptr = 0;
    bit m_acc, m_ev;
    int g, s;
    logic [N-1:0] eg, one;

    always @(negedge clk) begin
        if (rst) begin
            q_id.delete(); q_sum.delete(); q_co.delete(); q_rdy.delete();
            m_burst = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else begin
            m_acc = (q_id.size() < 2) || res_ready;
            m_ev  = (q_id.size() > 0) && (cyc >= q_rdy[0]);
            check("res_valid", 32'(res_valid), 32'(m_ev));
            if (m_ev) begin
                check("res_id", 32'(res_id), q_id[0]);
                check("res_sum", 32'(res_sum), q_sum[0]);
                check("res_co", 32'(res_co), q_co[0]);
            end
            g = -1;
            if (m_acc) begin
                if (!m_burst) begin
                    for (int k = 1; k <= N; k++)
                        if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    if (g >= 0) begin
                        m_ptr = g;
                        if (lock[g] && MAXB > 1) begin
                            m_burst = 1'b1; m_owner = g; m_cnt = 1;
                        end
                    end
                end else if (req[m_owner]) begin
                    g = m_owner;
                    if (lock[m_owner]) begin
                        m_cnt++;
                        if (m_cnt == MAXB) m_burst = 1'b0;
                    end else begin
                        m_burst = 1'b0;
                    end
                end else begin
                    m_burst = 1'b0;
                end
            end
            one = 1;
            eg  = (g >= 0) ? (one << g) : '0;
            check("gnt", 32'(gnt), 32'(eg));
            if (m_ev && res_ready) begin
                void'(q_id.pop_front()); void'(q_sum.pop_front());
                void'(q_co.pop_front()); void'(q_rdy.pop_front());
                if (q_rdy.size() > 0 && q_rdy[0] < cyc + 1) q_rdy[0] = cyc + 1;
            end
            if (g >= 0) begin
                s = int'(op_a[g*W +: W]) + int'(op_b[g*W +: W]) + int'(op_ci[g]);
                q_id.push_back(g);
                q_co.push_back((s >> W) & 1);
`ifdef ADD_ARB_SAT_EN
                q_sum.push_back((sat[g] && ((s >> W) & 1) == 1) ? (1 << W) - 1 : s % (1 << W));
`else
                q_sum.push_back(s % (1 << W));
`endif
                q_rdy.push_back(cyc + 2);
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] t2_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]   t2_id [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [N-1:0] t4_g [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    logic [N-1:0] t5_g [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

    initial begin
        rst = 1'b1; req = '0; lock = '0; op_a = '0; op_b = '0; op_ci = '0; res_ready = 1'b1;
`ifdef ADD_ARB_SAT_EN
        sat = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        #1 check("reset_valid", 32'(res_valid), 0);
        check("reset_sum", 32'(res_sum), 0);

        // single op from client 0
        tick();
        req = 4'b0001; op_a[7:0] = 8'h05; op_b[7:0] = 8'h03; op_ci = 4'b0001;
        #1 check("t1_gnt", 32'(gnt), 32'h1);
        tick(); req = '0;
        #1 check("t1_wait", 32'(res_valid), 0);
        tick();
        #1 check("t1_valid", 32'(res_valid), 1);
        check("t1_id", 32'(res_id), 0);
        check("t1_sum", 32'(res_sum), 32'h09);
        check("t1_co", 32'(res_co), 0);
        tick();

        // full round-robin stream
        op_a = 32'h31211101; op_b = 32'h22222222; op_ci = 4'b1010; req = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k < 4) check("t2_gnt", 32'(gnt), 32'(t2_g[k]));
            if (k >= 2) check("t2_id", 32'(res_id), 32'(t2_id[k-2]));
            tick();
        end
        req = '0;
        repeat (3) tick();

        // overflow: client 1 (saturating when enabled), then client 3 plain wrap
        op_a[15:8] = 8'hFF; op_b[15:8] = 8'h01; op_ci = '0; req = 4'b0010;
`ifdef ADD_ARB_SAT_EN
        sat = 4'b0010;
`endif
        #1 check("t3_gnt", 32'(gnt), 32'h2);
        tick(); req = '0;
        tick();
`ifdef ADD_ARB_SAT_EN
        #1 check("t3_sum", 32'(res_sum), 32'hFF);
        sat = '0;
`else
        #1 check("t3_sum", 32'(res_sum), 32'h00);
`endif
        check("t3_co", 32'(res_co), 1);
        op_a[31:24] = 8'h80; op_b[31:24] = 8'h80; op_ci = 4'b1000; req = 4'b1000;
        #1 check("t3b_gnt", 32'(gnt), 32'h8);
        tick(); req = '0;
        tick();
        #1 check("t3b_sum", 32'(res_sum), 32'h01);
        check("t3b_co", 32'(res_co), 1);
        tick();

        // burst lock on client 2
        req = 4'b0010;
        #1 check("t4_prep", 32'(gnt), 32'h2);
        tick(); req = '0;
        repeat (3) tick();
        req = 4'hF; lock = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1 check("t4_gnt", 32'(gnt), 32'(t4_g[k]));
            tick();
        end
        req = '0; lock = '0;
        repeat (4) tick();

        // backpressure from empty pipeline
        res_ready = 1'b0; req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 check("t5_gnt", 32'(gnt), 32'(t5_g[k]));
            tick();
        end
        res_ready = 1'b1;
        repeat (4) tick();
        req = '0;
        repeat (5) tick();

        // reset with both stages full
        req = 4'hF; res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        #1 check("t6_valid", 32'(res_valid), 0);
        check("t6_gnt", 32'(gnt), 0);
        res_ready = 1'b1;
        tick();
        req = 4'hF;
        #1 check("t6_rr", 32'(gnt), 32'h2);
        tick(); req = '0;
        repeat (4) tick();

        check("drain", 32'(q_id.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
